btb_update_sched: RTL and testbench

- Schedules branch-predictor training writes into the shared single-port BHT/BTB array.
- Resolved branch outcomes from the branch-resolution stage enter a small FIFO.
- Each entry drains as a read-modify-write of a 2-bit saturating counter plus a target/tag write.
- Fetch-stage lookups always have priority on the array port; updates use only the idle cycles.

---
 rtl/btb_update_sched.sv | 205 ++++++++++++++++++++
 tb/tb_btb_update_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_sched.sv
// btb_update_sched: queues resolved-branch outcomes and drains each one into the
// shared single-port BHT/BTB array during cycles that fetch does not own the port.
// Conditional entries run a read-modify-write of the 2-bit counter; unconditional
// entries write a strongly-taken counter directly.
// Optional build macro: BTB_UPD_PERF_EN adds perf_retired / perf_stall counters.
module btb_update_sched #(
  parameter int QUEUE_DEPTH = 4,
  parameter int IDX_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [15:0]          upd_pc,
  input  logic [15:0]          upd_target,
  input  logic                 upd_taken,
  input  logic                 upd_uncond,
  input  logic                 fetch_lookup,
  output logic                 tbl_req,
  output logic                 tbl_we,
  output logic [IDX_W-1:0]     tbl_idx,
  output logic [1:0]           tbl_wctr,
  output logic [15:0]          tbl_wtarget,
  output logic [16-IDX_W-2:0]  tbl_wtag,
  output logic                 tbl_wvalid,
  input  logic [1:0]           tbl_rctr,
  output logic                 busy
`ifdef BTB_UPD_PERF_EN
  ,
  output logic [15:0]          perf_retired,
  output logic [15:0]          perf_stall
`endif
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = 16 - IDX_W - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state, state_d;

  // Queue storage holds index/tag already split out of the PC.
  logic [IDX_W-1:0] q_idx    [QUEUE_DEPTH];
  logic [TAG_W-1:0] q_tag    [QUEUE_DEPTH];
  logic [15:0]      q_target [QUEUE_DEPTH];
  logic             q_taken  [QUEUE_DEPTH];
  logic             q_uncond [QUEUE_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, push, pop;

  // Working registers for the entry currently being retired.
  logic [IDX_W-1:0] wk_idx;
  logic [TAG_W-1:0] wk_tag;
  logic [15:0]      wk_target;
  logic             wk_taken, wk_uncond, wk_wvalid;
  logic [1:0]       wk_ctr, next_ctr;

  // PC bit 0 is never used: branches are word-aligned.
  logic pc_lsb_unused;
  assign pc_lsb_unused = upd_pc[0];

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(QUEUE_DEPTH));
  assign upd_ready = !full;
  assign push      = upd_valid && upd_ready;
  assign busy      = !empty || (state != S_IDLE);

  assign tbl_idx     = wk_idx;
  assign tbl_wctr    = wk_ctr;
  assign tbl_wtarget = wk_target;
  assign tbl_wtag    = wk_tag;
  assign tbl_wvalid  = wk_wvalid;

  // Queue payload write; contents need no reset since occupancy gates use.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]    <= upd_pc[IDX_W:1];
      q_tag[wr_ptr]    <= upd_pc[15:IDX_W+1];
      q_target[wr_ptr] <= upd_target;
      q_taken[wr_ptr]  <= upd_taken;
      q_uncond[wr_ptr] <= upd_uncond;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating counter update from the read data returned in WAIT.
  always_comb begin
    next_ctr = tbl_rctr;
    if (wk_taken) begin
      if (tbl_rctr != 2'b11) next_ctr = tbl_rctr + 2'd1;
    end else begin
      if (tbl_rctr != 2'b00) next_ctr = tbl_rctr - 2'd1;
    end
  end

  // Next-state and array-port control.
  // A completed WRITE pops the next entry directly instead of passing through
  // IDLE, so back-to-back entries keep the 3-cycle / 1-cycle retire rate.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    tbl_req = 1'b0;
    tbl_we  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = q_uncond[rd_ptr] ? S_WRITE : S_RD;
        end
      end
      S_RD: begin
        if (!fetch_lookup) begin
          tbl_req = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!fetch_lookup) begin
          tbl_req = 1'b1;
          tbl_we  = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = q_uncond[rd_ptr] ? S_WRITE : S_RD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Working entry: loaded on pop, counter/valid resolved in WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wk_idx    <= '0;
      wk_tag    <= '0;
      wk_target <= '0;
      wk_taken  <= 1'b0;
      wk_uncond <= 1'b0;
      wk_ctr    <= '0;
      wk_wvalid <= 1'b0;
    end else if (pop) begin
      wk_idx    <= q_idx[rd_ptr];
      wk_tag    <= q_tag[rd_ptr];
      wk_target <= q_target[rd_ptr];
      wk_taken  <= q_taken[rd_ptr];
      wk_uncond <= q_uncond[rd_ptr];
      wk_ctr    <= q_uncond[rd_ptr] ? '1 : '0;
      wk_wvalid <= q_uncond[rd_ptr];
    end else if (state == S_WAIT) begin
      wk_ctr    <= next_ctr;
      wk_wvalid <= next_ctr[1] || wk_uncond;
    end
  end

`ifdef BTB_UPD_PERF_EN
  // Retired-write and fetch-stall event counters, free-running with wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (state == S_WRITE && !fetch_lookup)
        perf_retired <= perf_retired + 16'd1;
      if ((state == S_RD || state == S_WRITE) && fetch_lookup)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_sched.sv
// Bench for btb_update_sched: a transaction-level model (pending-update list plus
// a counter array) predicts every array access; directed tests pin the model.
module tb_btb_update_sched;

  localparam int QD    = 4;
  localparam int IW    = 4;
  localparam int TAG_W = 16 - IW - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             upd_valid, upd_ready;
  logic [15:0]      upd_pc, upd_target;
  logic             upd_taken, upd_uncond;
  logic             fetch_lookup;
  logic             tbl_req, tbl_we;
  logic [IW-1:0]    tbl_idx;
  logic [1:0]       tbl_wctr;
  logic [15:0]      tbl_wtarget;
  logic [TAG_W-1:0] tbl_wtag;
  logic             tbl_wvalid;
  logic [1:0]       tbl_rctr = 2'b00;
  logic             busy;
`ifdef BTB_UPD_PERF_EN
  logic [15:0]      perf_retired, perf_stall;
`endif

  btb_update_sched #(.QUEUE_DEPTH(QD), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_uncond(upd_uncond),
    .fetch_lookup(fetch_lookup),
    .tbl_req(tbl_req), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_wctr(tbl_wctr), .tbl_wtarget(tbl_wtarget), .tbl_wtag(tbl_wtag),
    .tbl_wvalid(tbl_wvalid), .tbl_rctr(tbl_rctr), .busy(busy)
`ifdef BTB_UPD_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Array stand-in: 1-cycle read latency, preset port for test setup.
  logic [1:0]    mem [16] = '{default: 2'b00};
  logic          preset_en = 1'b0;
  logic [IW-1:0] preset_idx = '0;
  logic [1:0]    preset_val = 2'b00;

  always @(posedge clk) begin
    if (preset_en) mem[preset_idx] <= preset_val;
    else if (tbl_req && tbl_we) mem[tbl_idx] <= tbl_wctr;
    if (tbl_req && !tbl_we) tbl_rctr <= mem[tbl_idx];
  end

  // Model state.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] target;
    logic        taken;
    logic        uncond;
  } upd_t;

  upd_t        mq[$];
  logic [1:0]  mctr [16] = '{default: 2'b00};
  bit          rd_seen = 1'b0;
  int          cyc = 0;
  int          n_reads = 0, n_writes = 0;
  int          last_enq_cycle = 0, last_rd_cycle = 0, last_wr_cycle = 0;
  logic [IW-1:0]    last_rd_idx = '0, last_w_idx = '0;
  logic [1:0]       last_w_ctr = '0;
  logic             last_w_valid = 1'b0;
  logic [15:0]      last_w_target = '0;
  logic [TAG_W-1:0] last_w_tag = '0;
  logic [1:0]       wr_ctr_log[$];

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    upd_t       h;
    logic [1:0] ec;
    int         ei;
    if (!reset_n) begin
      mq.delete();
      rd_seen = 1'b0;
    end else begin
      chk("busy", busy, (mq.size() != 0));
      chk("port_conflict", tbl_req & fetch_lookup, 0);
      if (tbl_req) begin
        if (mq.size() == 0) begin
          chk("spurious_access", tbl_req, 0);
        end else begin
          h  = mq[0];
          ei = int'(h.pc[4:1]);
          if (!tbl_we) begin
            chk("rd_order", {h.uncond, rd_seen}, 0);
            chk("rd_idx", tbl_idx, h.pc[4:1]);
            rd_seen = 1'b1;
            n_reads++;
            last_rd_cycle = cyc;
            last_rd_idx = tbl_idx;
          end else begin
            if (h.uncond) ec = 2'd3;
            else if (h.taken) ec = (mctr[ei] == 2'd3) ? 2'd3 : mctr[ei] + 2'd1;
            else ec = (mctr[ei] == 2'd0) ? 2'd0 : mctr[ei] - 2'd1;
            chk("wr_after_rd", (h.uncond || rd_seen), 1);
            chk("wr_idx", tbl_idx, h.pc[4:1]);
            chk("wr_ctr", tbl_wctr, ec);
            chk("wr_valid", tbl_wvalid, (h.uncond || ec >= 2'd2));
            chk("wr_target", tbl_wtarget, h.target);
            chk("wr_tag", tbl_wtag, h.pc[15:5]);
            mctr[ei] = ec;
            void'(mq.pop_front());
            rd_seen = 1'b0;
            n_writes++;
            last_wr_cycle = cyc;
            last_w_idx = tbl_idx;
            last_w_ctr = tbl_wctr;
            last_w_valid = tbl_wvalid;
            last_w_target = tbl_wtarget;
            last_w_tag = tbl_wtag;
            wr_ctr_log.push_back(tbl_wctr);
          end
        end
      end
      if (upd_valid && upd_ready) begin
        mq.push_back('{pc: upd_pc, target: upd_target, taken: upd_taken, uncond: upd_uncond});
        last_enq_cycle = cyc;
      end
      if (preset_en) mctr[int'(preset_idx)] = preset_val;
    end
    cyc++;
  end

  task automatic set_ctr(input logic [IW-1:0] idx, input logic [1:0] val);
    @(posedge clk); #1;
    preset_en = 1'b1; preset_idx = idx; preset_val = val;
    @(posedge clk); #1;
    preset_en = 1'b0;
  endtask

  task automatic send(input logic [15:0] pc, input logic [15:0] tgt,
                      input logic tk, input logic un, output bit acc);
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_uncond = un;
    @(negedge clk);
    acc = upd_ready;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_timeout", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},    tbl_req, 0);
    chk({tag, "_we"},     tbl_we, 0);
    chk({tag, "_idx"},    tbl_idx, 0);
    chk({tag, "_wctr"},   tbl_wctr, 0);
    chk({tag, "_wtgt"},   tbl_wtarget, 0);
    chk({tag, "_wtag"},   tbl_wtag, 0);
    chk({tag, "_wvalid"}, tbl_wvalid, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_ready"},  upd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int w0, r0, nacc;
    bit got_rd;
    reset_n = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; upd_uncond = 1'b0; fetch_lookup = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Conditional taken at ctr=1: read idx 9, write ctr 2 valid 1 tag 0.
    set_ctr(4'd9, 2'd1);
    w0 = n_writes;
    send(16'h0012, 16'h0100, 1'b1, 1'b0, acc);
    chk("t1_acc", acc, 1);
    wait_idle(20);
    chk("t1_nwr", n_writes - w0, 1);
    chk("t1_rd_idx", last_rd_idx, 9);
    chk("t1_rd_lat", last_rd_cycle - last_enq_cycle, 2);
    chk("t1_wr_lat", last_wr_cycle - last_enq_cycle, 4);
    chk("t1_w_idx", last_w_idx, 9);
    chk("t1_w_ctr", last_w_ctr, 2);
    chk("t1_w_valid", last_w_valid, 1);
    chk("t1_w_tag", last_w_tag, 0);
    chk("t1_w_tgt", last_w_target, 16'h0100);

    // Not-taken at ctr=0 saturates low and invalidates.
    set_ctr(4'd3, 2'd0);
    send(16'hA006, 16'h2222, 1'b0, 1'b0, acc);
    wait_idle(20);
    chk("t2_w_idx", last_w_idx, 3);
    chk("t2_w_ctr", last_w_ctr, 0);
    chk("t2_w_valid", last_w_valid, 0);
    chk("t2_w_tag", last_w_tag, 11'h500);

    // Taken at ctr=3 saturates high.
    set_ctr(4'd5, 2'd3);
    send(16'h000A, 16'h3333, 1'b1, 1'b0, acc);
    wait_idle(20);
    chk("t3_w_idx", last_w_idx, 5);
    chk("t3_w_ctr", last_w_ctr, 3);
    chk("t3_w_valid", last_w_valid, 1);

    // Unconditional: one write, no read.
    r0 = n_reads; w0 = n_writes;
    send(16'h0040, 16'h1234, 1'b0, 1'b1, acc);
    wait_idle(20);
    chk("t4_no_read", n_reads - r0, 0);
    chk("t4_nwr", n_writes - w0, 1);
    chk("t4_wr_lat", last_wr_cycle - last_enq_cycle, 2);
    chk("t4_w_idx", last_w_idx, 0);
    chk("t4_w_ctr", last_w_ctr, 3);
    chk("t4_w_valid", last_w_valid, 1);
    chk("t4_w_tgt", last_w_target, 16'h1234);
    chk("t4_w_tag", last_w_tag, 2);

    // Fetch holds the port: one entry parks in RD, queue then fills at 4.
    @(posedge clk); #1;
    fetch_lookup = 1'b1;
    r0 = n_reads; w0 = n_writes;
    send(16'h0002, 16'h4000, 1'b1, 1'b0, acc);
    chk("t5_first_acc", acc, 1);
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      send(16'(16'h0004 + 2 * i), 16'(16'h4100 + i), 1'b1, 1'b0, acc);
      if (acc) nacc++;
      if (i == 4) chk("t5_fifth_ready", acc, 0);
    end
    chk("t5_accepted", nacc, 4);
    chk("t5_ready_low", upd_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_access", (n_reads - r0) + (n_writes - w0), 0);
    fetch_lookup = 1'b0;
    wait_idle(60);
    chk("t5_nwr", n_writes - w0, 5);
    chk("t5_last_idx", last_w_idx, 5);
    chk("t5_last_tgt", last_w_target, 16'h4103);

    // Same index twice from ctr=1 compounds to 2 then 3.
    set_ctr(4'd7, 2'd1);
    wr_ctr_log.delete();
    send(16'h000E, 16'h5000, 1'b1, 1'b0, acc);
    send(16'h000E, 16'h5001, 1'b1, 1'b0, acc);
    wait_idle(40);
    chk("t6_nwr", wr_ctr_log.size(), 2);
    if (wr_ctr_log.size() == 2) begin
      chk("t6_ctr0", wr_ctr_log[0], 2);
      chk("t6_ctr1", wr_ctr_log[1], 3);
    end

    // Reset asserted during WAIT with two entries still queued.
    @(posedge clk); #1;
    fetch_lookup = 1'b1;
    send(16'h0022, 16'h6000, 1'b1, 1'b0, acc);
    send(16'h0024, 16'h6001, 1'b1, 1'b0, acc);
    send(16'h0026, 16'h6002, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    fetch_lookup = 1'b0;
    got_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tbl_req && !tbl_we) begin
        got_rd = 1'b1;
        break;
      end
    end
    chk("t7_read_seen", got_rd, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t7_rst");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk("t7_busy_after", busy, 0);
    chk("t7_ready_after", upd_ready, 1);

    // Normal operation resumes after the reset.
    set_ctr(4'd9, 2'd2);
    send(16'h0012, 16'h7000, 1'b1, 1'b0, acc);
    wait_idle(20);
    chk("t8_w_idx", last_w_idx, 9);
    chk("t8_w_ctr", last_w_ctr, 3);
    chk("t8_w_tgt", last_w_target, 16'h7000);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
